// File: rtl/lint_pkg.sv
// Shared types and constants for the LINT memory slave: grant FSM states
// and the word-index width derived from the memory depth.
package lint_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam int DEPTH_DEFAULT = 256;

  function automatic int idx_of(input int depth);
    return $clog2(depth);
  endfunction

  // Word-index width for the default depth; instances recompute via idx_of.
  localparam int IDX = idx_of(DEPTH_DEFAULT);

endpackage

// File: rtl/lint_sram.sv
// Single-port synchronous SRAM with per-byte write enables and a registered
// read port. Contents are deliberately left unreset.
module lint_sram
  import lint_pkg::*;
#(
  parameter int DATA_WD = 32,
  parameter int BE_WD   = DATA_WD / 8,
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int AW      = idx_of(DEPTH)
) (
  input  logic               clk,
  input  logic               en,
  input  logic               we,
  input  logic [BE_WD-1:0]   be,
  input  logic [AW-1:0]      addr,
  input  logic [DATA_WD-1:0] wdata,
  output logic [DATA_WD-1:0] rdata
);

  logic [DATA_WD-1:0] mem [DEPTH];
  logic [DATA_WD-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < BE_WD; b++) begin
          if (be[b]) begin
            mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
          end
        end
      end else begin
        rdata_reg <= mem[addr];
      end
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/lint_mem_slave.sv
// LINT-protocol memory slave: programmable grant wait states, range check,
// one-cycle response after every grant, backed by a byte-writable SRAM.
module lint_mem_slave
  import lint_pkg::*;
#(
  parameter int DATA_WD = 32,
  parameter int ADDR_WD = 32,
  parameter int BE_WD   = DATA_WD / 8,
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int WAIT_WD = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               lint_req_i,
  input  logic               lint_we_i,
  input  logic [DATA_WD-1:0] lint_wdata_i,
  input  logic [BE_WD-1:0]   lint_be_i,
  input  logic [ADDR_WD-1:0] lint_addr_i,
  output logic               lint_gnt_o,
  output logic               lint_rvalid_o,
  output logic [DATA_WD-1:0] lint_rdata_o,
  output logic               lint_err_o,
  input  logic [WAIT_WD-1:0] cfg_wait_i
);

  localparam int IDX_W = idx_of(DEPTH);

  state_e             state_reg, state_next;
  logic [WAIT_WD-1:0] cnt_reg, cnt_next;
  logic               gnt;

  logic [IDX_W-1:0]   word_idx;
  logic               out_of_range;
  logic               unused_addr_lsb;

  logic               rvalid_reg;
  logic               resp_read_reg;
  logic               resp_err_reg;
  logic [DATA_WD-1:0] sram_rdata;

  assign word_idx        = lint_addr_i[IDX_W+1:2];
  assign unused_addr_lsb = ^lint_addr_i[1:0];

  generate
    if (ADDR_WD > IDX_W + 2) begin : g_range
      assign out_of_range = |lint_addr_i[ADDR_WD-1:IDX_W+2];
    end else begin : g_no_range
      assign out_of_range = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // cfg_wait_i is only looked at in IDLE, so a pending request keeps the
  // latency it started with.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    gnt        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (lint_req_i) begin
          if (cfg_wait_i == '0) begin
            gnt = 1'b1;
          end else begin
            cnt_next   = cfg_wait_i - WAIT_WD'(1);
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!lint_req_i) begin
          state_next = ST_IDLE;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - WAIT_WD'(1);
        end else begin
          gnt        = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // A request coinciding with reset is never granted.
    if (rst_i) begin
      gnt = 1'b0;
    end
  end

  assign lint_gnt_o = gnt;

  lint_sram #(
    .DATA_WD (DATA_WD),
    .BE_WD   (BE_WD),
    .DEPTH   (DEPTH),
    .AW      (IDX_W)
  ) u_sram (
    .clk   (clk_i),
    .en    (gnt && !out_of_range),
    .we    (lint_we_i),
    .be    (lint_be_i),
    .addr  (word_idx),
    .wdata (lint_wdata_i),
    .rdata (sram_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_reg    <= 1'b0;
      resp_read_reg <= 1'b0;
      resp_err_reg  <= 1'b0;
    end else begin
      rvalid_reg    <= gnt;
      resp_read_reg <= gnt && !lint_we_i && !out_of_range;
      resp_err_reg  <= gnt && out_of_range;
    end
  end

  assign lint_rvalid_o = rvalid_reg;
  assign lint_err_o    = resp_err_reg;
  assign lint_rdata_o  = resp_read_reg ? sram_rdata : '0;

endmodule
